// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB)
// Optional statistics counters: define PIPE_STAGE_STATS_EN to build hold_cnt/bubble_cnt.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W   = 108,
  parameter int                   STALL_IDX   = 2,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}},
  parameter int                   CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_delayslot_next,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_delayslot,
  output logic [1:0]           out_state,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // Upstream / downstream stall bits for this stage's position in the pipe.
  logic up;
  logic dn;
  assign up = stall[STALL_IDX];
  assign dn = stall[STALL_IDX+1];

  // The other stall bits belong to other stages; reduced here only so they
  // are visibly consumed.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Stage actions below reset, in priority order. up=0 with dn=1 cannot come
  // from a sane control block and simply falls through to a load.
  logic do_bubble;
  logic do_hold;
  assign do_bubble = !flush && up && !dn;
  assign do_hold   = !flush && up && dn;

  state_t                 state_q;
  state_t                 state_d;
  logic                   valid_q;
  logic                   valid_d;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [PAYLOAD_W-1:0]   payload_d;
  logic                   ds_q;
  logic                   ds_d;

  // Register update; reset drops everything to an empty NOP slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      payload_q <= NOP_PAYLOAD;
      ds_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ds_q      <= ds_d;
    end
  end

  // Next-state selection: flush > bubble > hold > load.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    ds_d      = ds_q;
    if (flush) begin
      state_d   = ST_EMPTY;
      valid_d   = 1'b0;
      payload_d = NOP_PAYLOAD;
      ds_d      = 1'b0;
    end else if (do_bubble) begin
      // The delay-slot flag is kept so that a load-use stall does not lose
      // the fact that the waiting instruction sits in a delay slot.
      state_d   = ST_EMPTY;
      valid_d   = 1'b0;
      payload_d = NOP_PAYLOAD;
    end else if (do_hold) begin
      // Contents frozen; HELD is reported even if the slot was empty.
      state_d   = ST_HELD;
    end else begin
      // Payload is captured even when invalid; consumers gate on out_valid.
      state_d   = in_valid ? ST_LOADED : ST_EMPTY;
      valid_d   = in_valid;
      payload_d = in_payload;
      ds_d      = in_delayslot_next;
    end
  end

  assign out_state     = state_q;
  assign out_valid     = valid_q;
  assign out_payload   = payload_q;
  assign out_delayslot = ds_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  // Statistics counters; flush edges are never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Saturating increments: stick at all-ones rather than wrapping.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (do_hold && (hold_cnt_q != {CNT_W{1'b1}})) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
    if (do_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign hold_cnt   = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int PW = 108;
  localparam int CW = 4;
`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic [PW-1:0] in_payload;
  logic          in_delayslot_next;
  logic          out_valid;
  logic [PW-1:0] out_payload;
  logic          out_delayslot;
  logic [1:0]    out_state;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_reg #(
    .PAYLOAD_W  (PW),
    .STALL_IDX  (2),
    .NOP_PAYLOAD({PW{1'b0}}),
    .CNT_W      (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_payload       (in_payload),
    .in_delayslot_next(in_delayslot_next),
    .out_valid        (out_valid),
    .out_payload      (out_payload),
    .out_delayslot    (out_delayslot),
    .out_state        (out_state),
    .hold_cnt         (hold_cnt),
    .bubble_cnt       (bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          v;
    logic [PW-1:0] p;
    logic          ds;
    logic          ev;
    logic [PW-1:0] ep;
    logic          eds;
    logic [1:0]    est;
    int            eh;
    int            eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] s, input logic f, input logic v,
                     input logic [PW-1:0] p, input logic ds, input logic ev,
                     input logic [PW-1:0] ep, input logic eds, input logic [1:0] est,
                     input int eh, input int eb);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.v = v; t.p = p; t.ds = ds;
    t.ev = ev; t.ep = ep; t.eds = eds; t.est = est; t.eh = eh; t.eb = eb;
    vecs.push_back(t);
  endtask

  function automatic logic [CW-1:0] cexp(input int n);
    int m;
    m = (n > 15) ? 15 : n;
    return STATS ? CW'(m) : '0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [PW-1:0] ep,
                            input logic eds, input logic [1:0] est, input int eh, input int eb);
    chk({tag, ".valid"},    128'(out_valid),     128'(ev));
    chk({tag, ".payload"},  128'(out_payload),   128'(ep));
    chk({tag, ".delayslot"},128'(out_delayslot), 128'(eds));
    chk({tag, ".state"},    128'(out_state),     128'(est));
    chk({tag, ".hold_cnt"}, 128'(hold_cnt),      128'(cexp(eh)));
    chk({tag, ".bubble_cnt"},128'(bubble_cnt),   128'(cexp(eb)));
  endtask

  logic [PW-1:0] ones;
  logic [PW-1:0] p5a;
  logic [PW-1:0] z;

  initial begin
    ones = '1;
    p5a  = {4'hA, {13{8'h5A}}};
    z    = '0;

    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b1;
    in_payload = ones; in_delayslot_next = 1'b1;

    //   rst  stall       fl  v   payload        ds  ev  exp_payload    eds st     h  b
    add(1, 6'b000000, 0, 1, ones,          1,  0, z,             0, 2'd0, 0, 0); // 0 reset
    add(1, 6'b000000, 0, 1, ones,          1,  0, z,             0, 2'd0, 0, 0); // 1 reset
    add(0, 6'b000000, 0, 1, p5a,           1,  1, p5a,           1, 2'd1, 0, 0); // 2 load 5A
    add(0, 6'b000000, 0, 1, PW'('h123),    0,  1, PW'('h123),    0, 2'd1, 0, 0); // 3 load 123
    add(0, 6'b001111, 0, 0, PW'('hABC),    1,  1, PW'('h123),    0, 2'd2, 1, 0); // 4 hold
    add(0, 6'b001111, 0, 0, PW'('hABC),    1,  1, PW'('h123),    0, 2'd2, 2, 0); // 5 hold
    add(0, 6'b001111, 0, 0, PW'('hABC),    1,  1, PW'('h123),    0, 2'd2, 3, 0); // 6 hold
    add(0, 6'b000000, 0, 1, PW'('h77),     1,  1, PW'('h77),     1, 2'd1, 3, 0); // 7 load ds
    add(0, 6'b000100, 0, 1, PW'('h99),     0,  0, z,             1, 2'd0, 3, 1); // 8 bubble
    add(0, 6'b001100, 0, 1, PW'('h98),     0,  0, z,             1, 2'd2, 4, 1); // 9 hold empty
    add(0, 6'b000000, 0, 0, PW'('h3C),     0,  0, PW'('h3C),     0, 2'd0, 4, 1); // 10 load invalid
    add(0, 6'b000000, 0, 1, PW'('h55),     0,  1, PW'('h55),     0, 2'd1, 4, 1); // 11 load
    add(0, 6'b001111, 0, 1, PW'('h56),     1,  1, PW'('h55),     0, 2'd2, 5, 1); // 12 hold
    add(0, 6'b001111, 1, 1, PW'('h57),     1,  0, z,             0, 2'd0, 5, 1); // 13 flush in hold
    add(0, 6'b001000, 0, 1, PW'('h42),     1,  1, PW'('h42),     1, 2'd1, 5, 1); // 14 illegal=load
    add(0, 6'b000000, 1, 1, PW'('h43),     1,  0, z,             0, 2'd0, 5, 1); // 15 flush
    add(0, 6'b000000, 0, 1, PW'('h11),     0,  1, PW'('h11),     0, 2'd1, 5, 1); // 16 load
    add(0, 6'b001100, 0, 1, PW'('h12),     0,  1, PW'('h11),     0, 2'd2, 6, 1); // 17 hold
    add(1, 6'b001100, 0, 1, PW'('h13),     1,  0, z,             0, 2'd0, 0, 0); // 18 rst in hold
    add(0, 6'b110011, 0, 1, PW'('h66),     0,  1, PW'('h66),     0, 2'd1, 0, 0); // 19 foreign bits
    add(0, 6'b110111, 0, 1, PW'('h67),     1,  0, z,             0, 2'd0, 0, 1); // 20 bubble

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
      in_valid = vecs[i].v; in_payload = vecs[i].p; in_delayslot_next = vecs[i].ds;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ep, vecs[i].eds,
                 vecs[i].est, vecs[i].eh, vecs[i].eb);
    end

    // Bubble counter saturation (counter is at 1 after the last vector).
    for (int i = 0; i < 20; i++) begin
      stall = 6'b000100; flush = 1'b0; rst = 1'b0; in_valid = 1'b1; in_payload = PW'(i);
      @(posedge clk); #1;
      chk($sformatf("bsat%0d.bubble_cnt", i), 128'(bubble_cnt), 128'(cexp(2 + i)));
      chk($sformatf("bsat%0d.valid", i), 128'(out_valid), 128'(1'b0));
    end

    // Hold counter saturation from zero.
    for (int i = 0; i < 20; i++) begin
      stall = 6'b001100;
      @(posedge clk); #1;
      chk($sformatf("hsat%0d.hold_cnt", i), 128'(hold_cnt), 128'(cexp(1 + i)));
    end
    chk("hsat.bubble_cnt", 128'(bubble_cnt), 128'(cexp(15)));

    // One-cycle latency and no combinational path: inputs move mid-cycle.
    stall = 6'b000000; in_valid = 1'b1; in_payload = PW'('hBEEF); in_delayslot_next = 1'b0;
    @(posedge clk); #1;
    chk("lat.load", 128'(out_payload), 128'(PW'('hBEEF)));
    in_payload = PW'('hCAFE); in_valid = 1'b0; in_delayslot_next = 1'b1;
    #3;
    chk("lat.comb_payload", 128'(out_payload), 128'(PW'('hBEEF)));
    chk("lat.comb_valid",   128'(out_valid),   128'(1'b1));
    chk("lat.comb_ds",      128'(out_delayslot), 128'(1'b0));
    @(posedge clk); #1;
    check_outs("lat.next", 1'b0, PW'('hCAFE), 1'b1, 2'd0, 15, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
